// File: rtl/pipe_control_unit_if.sv
// Port bundle for the pipelined main control: ID-stage fields in, staged
// control words, destinations and hazard/illegal status out.
interface pipe_control_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 8
);
  // id_valid qualifies the ID fields for the current cycle. There is no ready:
  // the only back-pressure is stall, and the datapath re-presents the same
  // instruction on the cycle after stall is seen high.
  logic             id_valid;
  logic [5:0]       opCode;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             flush;

  logic [3:0]       ex_ctrl;
  logic [REG_W-1:0] ex_rt;
  logic [2:0]       mem_ctrl;
  logic [REG_W-1:0] mem_dest;
  logic [1:0]       wb_ctrl;
  logic [REG_W-1:0] wb_dest;
  logic             stall;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output id_valid, opCode, id_rs, id_rt, id_rd, flush,
    input  ex_ctrl, ex_rt, mem_ctrl, mem_dest, wb_ctrl, wb_dest,
    input  stall, illegal, illegal_cnt
  );

  modport slave (
    input  id_valid, opCode, id_rs, id_rt, id_rd, flush,
    output ex_ctrl, ex_rt, mem_ctrl, mem_dest, wb_ctrl, wb_dest,
    output stall, illegal, illegal_cnt
  );
endinterface

// File: rtl/pipe_control_unit.sv
// MIPS pipelined main control: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, load-use stall, branch flush and illegal-opcode accounting.
module pipe_control_unit #(
  parameter int REG_W     = 5,
  parameter bit HAZARD_EN = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_control_unit_if.slave   bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Control word bit order:
  // [8] RegDst [7] ALUSrc [6] MemtoReg [5] RegWrite
  // [4] MemRead [3] MemWrite [2] Branch [1:0] ALUOp
  logic [8:0]       dec_word;
  logic             dec_legal;
  logic             reads_rt;
  logic [REG_W-1:0] dec_dest;

  always_comb begin
    dec_word  = 9'b000_000_000;
    dec_legal = 1'b0;
    reads_rt  = 1'b0;
    case (bus.opCode)
      OP_RTYPE: begin dec_word = 9'b100_100_010; dec_legal = 1'b1; reads_rt = 1'b1; end
      OP_LB:    begin dec_word = 9'b011_110_000; dec_legal = 1'b1; end
      OP_SB:    begin dec_word = 9'b010_001_000; dec_legal = 1'b1; reads_rt = 1'b1; end
      OP_BEQ:   begin dec_word = 9'b000_000_101; dec_legal = 1'b1; reads_rt = 1'b1; end
      OP_ADDI:  begin dec_word = 9'b010_100_000; dec_legal = 1'b1; end
      default:  begin dec_word = 9'b000_000_000; dec_legal = 1'b0; end
    endcase
    if (!bus.id_valid) dec_word = 9'b000_000_000;
  end

  assign dec_dest = dec_word[8] ? bus.id_rd : bus.id_rt;

  // ID/EX
  logic [3:0]       idex_ex;
  logic [2:0]       idex_m;
  logic [1:0]       idex_wb;
  logic [REG_W-1:0] idex_dest;
  logic [REG_W-1:0] idex_rt;
  // EX/MEM
  logic [2:0]       exmem_m;
  logic [1:0]       exmem_wb;
  logic [REG_W-1:0] exmem_dest;
  // MEM/WB
  logic [1:0]       memwb_wb;
  logic [REG_W-1:0] memwb_dest;

  logic             illegal_q;
  logic [CNT_W-1:0] illegal_cnt_q;

  // A load whose target is $0 never creates a dependence.
  logic load_use;
  logic stall;
  logic illegal_hit;

  assign load_use = bus.id_valid & idex_m[2] & (idex_rt != '0) &
                    ((idex_rt == bus.id_rs) | (reads_rt & (idex_rt == bus.id_rt)));
  assign stall       = HAZARD_EN & load_use;
  assign illegal_hit = bus.id_valid & ~dec_legal & ~stall & ~bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_ex   <= '0;
      idex_m    <= '0;
      idex_wb   <= '0;
      idex_dest <= '0;
      idex_rt   <= '0;
    end else if (bus.flush | stall) begin
      idex_ex   <= '0;
      idex_m    <= '0;
      idex_wb   <= '0;
      idex_dest <= '0;
      idex_rt   <= '0;
    end else begin
      idex_ex   <= {dec_word[8], dec_word[7], dec_word[1:0]};
      idex_m    <= dec_word[4:2];
      idex_wb   <= dec_word[6:5];
      idex_dest <= dec_dest;
      idex_rt   <= bus.id_rt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exmem_m    <= '0;
      exmem_wb   <= '0;
      exmem_dest <= '0;
    end else if (bus.flush) begin
      exmem_m    <= '0;
      exmem_wb   <= '0;
      exmem_dest <= '0;
    end else begin
      exmem_m    <= idex_m;
      exmem_wb   <= idex_wb;
      exmem_dest <= idex_dest;
    end
  end

  // The branch resolving in MEM is older than the flush, so MEM/WB keeps it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memwb_wb   <= '0;
      memwb_dest <= '0;
    end else begin
      memwb_wb   <= exmem_wb;
      memwb_dest <= exmem_dest;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      illegal_q <= illegal_hit;
      if (illegal_hit && (illegal_cnt_q != CNT_MAX))
        illegal_cnt_q <= illegal_cnt_q + CNT_ONE;
    end
  end

  assign bus.ex_ctrl     = idex_ex;
  assign bus.ex_rt       = idex_rt;
  assign bus.mem_ctrl    = exmem_m;
  assign bus.mem_dest    = exmem_dest;
  assign bus.wb_ctrl     = memwb_wb;
  assign bus.wb_dest     = memwb_dest;
  assign bus.stall       = stall;
  assign bus.illegal     = illegal_q;
  assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: directed scenarios then random traffic, all
// compared against an instruction-level model of the three control stages.
module tb_pipe_control_unit;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 8;
  localparam int CNT_W2 = 2;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] BAD = 6'b111111;

  logic clk = 1'b0;
  logic reset;

  pipe_control_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W))  bus ();
  pipe_control_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W2)) bus2 ();

  pipe_control_unit #(.REG_W(REG_W), .HAZARD_EN(1'b1), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  pipe_control_unit #(.REG_W(REG_W), .HAZARD_EN(1'b1), .CNT_W(CNT_W2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [8:0]       c;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] rt;
  } stage_t;

  stage_t m_ex, m_mem, m_wb, zero_stage;
  logic   m_illegal;
  int     m_cnt;

  logic             s_valid, s_flush;
  logic [5:0]       s_op;
  logic [REG_W-1:0] s_rs, s_rt, s_rd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic logic [8:0] ref_word(input logic [5:0] op);
    case (op)
      6'd0:    return 9'b100100010;
      6'd32:   return 9'b011110000;
      6'd40:   return 9'b010001000;
      6'd4:    return 9'b000000101;
      6'd8:    return 9'b010100000;
      default: return 9'b000000000;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [5:0] op);
    return op inside {6'd0, 6'd32, 6'd40, 6'd4, 6'd8};
  endfunction

  function automatic bit ref_reads_rt(input logic [5:0] op);
    return op inside {6'd0, 6'd40, 6'd4};
  endfunction

  function automatic bit ref_stall();
    return s_valid && m_ex.c[4] && (m_ex.rt != 0) &&
           ((m_ex.rt == s_rs) || (ref_reads_rt(s_op) && (m_ex.rt == s_rt)));
  endfunction

  task automatic model_reset();
    zero_stage = '{c: 9'd0, dest: '0, rt: '0};
    m_ex = zero_stage; m_mem = zero_stage; m_wb = zero_stage;
    m_illegal = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    logic [8:0] w;
    bit st;
    w  = s_valid ? ref_word(s_op) : 9'd0;
    st = ref_stall();
    m_illegal = s_valid && !ref_legal(s_op) && !st && !s_flush;
    if (m_illegal) m_cnt++;
    m_wb  = m_mem;
    m_mem = s_flush ? zero_stage : m_ex;
    if (s_flush || st) m_ex = zero_stage;
    else begin
      m_ex.c    = w;
      m_ex.dest = w[8] ? s_rd : s_rt;
      m_ex.rt   = s_rt;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_cnt, e_cnt2;
    e_cnt  = (m_cnt > 255) ? 32'd255 : 32'(m_cnt);
    e_cnt2 = (m_cnt > 3)   ? 32'd3   : 32'(m_cnt);
    chk("ex_ctrl",      bus.ex_ctrl,  {m_ex.c[8], m_ex.c[7], m_ex.c[1:0]});
    chk("ex_rt",        bus.ex_rt,    m_ex.rt);
    chk("mem_ctrl",     bus.mem_ctrl, m_mem.c[4:2]);
    chk("mem_dest",     bus.mem_dest, m_mem.dest);
    chk("wb_ctrl",      bus.wb_ctrl,  m_wb.c[6:5]);
    chk("wb_dest",      bus.wb_dest,  m_wb.dest);
    chk("stall",        bus.stall,    ref_stall());
    chk("illegal",      bus.illegal,  m_illegal);
    chk("illegal_cnt",  bus.illegal_cnt, e_cnt);
    chk("stall2",       bus2.stall,   ref_stall());
    chk("illegal_cnt2", bus2.illegal_cnt, e_cnt2);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [5:0] op, input logic [REG_W-1:0] rs,
                       input logic [REG_W-1:0] rt, input logic [REG_W-1:0] rd, input logic fl);
    s_valid = v; s_op = op; s_rs = rs; s_rt = rt; s_rd = rd; s_flush = fl;
    bus.id_valid  = v;  bus.opCode  = op; bus.id_rs  = rs; bus.id_rt  = rt;
    bus.id_rd     = rd; bus.flush   = fl;
    bus2.id_valid = v;  bus2.opCode = op; bus2.id_rs = rs; bus2.id_rt = rt;
    bus2.id_rd    = rd; bus2.flush  = fl;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic cycle(input logic v, input logic [5:0] op, input logic [REG_W-1:0] rs,
                       input logic [REG_W-1:0] rt, input logic [REG_W-1:0] rd, input logic fl);
    drive(v, op, rs, rt, rd, fl);
    #1;
    check_all();
    clock_edge();
  endtask

  task automatic idle();
    cycle(1'b0, 6'd0, '0, '0, '0, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [5:0] ops [5];
    ops[0] = 6'd0; ops[1] = 6'd32; ops[2] = 6'd40; ops[3] = 6'd4; ops[4] = 6'd8;

    reset = 1'b1;
    drive(1'b0, 6'd0, '0, '0, '0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all();
    chk("rst_ex_ctrl", bus.ex_ctrl, 4'b0000);
    chk("rst_stall",   bus.stall,   1'b0);
    @(negedge clk);
    reset = 1'b0;

    // R-type latency through the three stages
    cycle(1'b1, RT, 5'd1, 5'd2, 5'd3, 1'b0);
    chk("rtype_ex", bus.ex_ctrl, 4'b1010);
    idle();
    chk("rtype_mem",  bus.mem_ctrl, 3'b000);
    chk("rtype_mdst", bus.mem_dest, 5'd3);
    idle();
    chk("rtype_wb",   bus.wb_ctrl, 2'b01);
    chk("rtype_wdst", bus.wb_dest, 5'd3);

    // load-use: one stall cycle, one bubble, dependent op one cycle late
    cycle(1'b1, LB, 5'd0, 5'd5, 5'd0, 1'b0);
    drive(1'b1, RT, 5'd5, 5'd1, 5'd6, 1'b0);
    #1; check_all();
    chk("lu_stall", bus.stall, 1'b1);
    clock_edge();
    chk("lu_bubble", bus.ex_ctrl, 4'b0000);
    #1; check_all();
    chk("lu_stall_clear", bus.stall, 1'b0);
    clock_edge();
    chk("lu_late", bus.ex_ctrl, 4'b1010);

    // lb does not read rt; load into $0 never stalls
    cycle(1'b1, LB, 5'd0, 5'd5, 5'd0, 1'b0);
    drive(1'b1, LB, 5'd7, 5'd5, 5'd0, 1'b0);
    #1; check_all();
    chk("lb_lb_nostall", bus.stall, 1'b0);
    clock_edge();
    cycle(1'b1, LB, 5'd0, 5'd0, 5'd0, 1'b0);
    drive(1'b1, RT, 5'd0, 5'd0, 5'd1, 1'b0);
    #1; check_all();
    chk("r0_nostall", bus.stall, 1'b0);
    clock_edge();

    // lb, sb, then flush
    cycle(1'b1, LB, 5'd0, 5'd4, 5'd0, 1'b0);
    cycle(1'b1, SB, 5'd1, 5'd2, 5'd0, 1'b0);
    cycle(1'b0, 6'd0, '0, '0, '0, 1'b1);
    chk("fl_ex",   bus.ex_ctrl,  4'b0000);
    chk("fl_mem",  bus.mem_ctrl, 3'b000);
    chk("fl_wb",   bus.wb_ctrl,  2'b11);
    chk("fl_wdst", bus.wb_dest,  5'd4);
    idle();

    // illegal opcodes and counter saturation
    cycle(1'b1, BAD, '0, '0, '0, 1'b0);
    chk("ill_pulse", bus.illegal, 1'b1);
    chk("ill_cnt1",  bus.illegal_cnt, 8'd1);
    chk("ill_bubble", bus.ex_ctrl, 4'b0000);
    idle();
    chk("ill_pulse_end", bus.illegal, 1'b0);
    repeat (4) cycle(1'b1, BAD, '0, '0, '0, 1'b0);
    chk("ill_cnt5", bus.illegal_cnt, 8'd5);
    chk("ill_sat",  bus2.illegal_cnt, 2'd3);
    idle();

    // asynchronous reset between edges with lb in EX/MEM and a pending stall
    cycle(1'b1, LB, 5'd0, 5'd6, 5'd0, 1'b0);
    cycle(1'b1, LB, 5'd0, 5'd9, 5'd0, 1'b0);
    drive(1'b1, RT, 5'd9, 5'd0, 5'd1, 1'b0);
    #1; check_all();
    chk("pre_rst_stall", bus.stall,    1'b1);
    chk("pre_rst_mem",   bus.mem_ctrl, 3'b100);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("arst_mem",   bus.mem_ctrl,    3'b000);
    chk("arst_cnt",   bus.illegal_cnt, 8'd0);
    chk("arst_stall", bus.stall,       1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 6'd0, '0, '0, '0, 1'b0);

    // random traffic, small register range to make hazards frequent
    repeat (400) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 4)];
      else op = 6'($urandom_range(0, 63));
      cycle(1'($urandom_range(0, 9) != 0), op,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 9) == 0));
    end
    #1;
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
